// File: rtl/vdc_read_port.sv
// ---------------------------------------------------------------------------
// vdc_read_port
//
// CPU read side of the VDC register interface. Returns bytes to the CPU bus
// from the status register or the VRAM Read Register (VRR). The block owns the
// VRAM read address (MARR copy) and prefetches VRAM words into the VRR latch.
// After each high-byte VRR read it steps the read address and fetches the next
// word.
//
// Optional feature macro: READ_BUSY_STATUS_EN
//   defined   : status bit 6 also reads 1 while a VRAM fetch is outstanding
//   undefined : status_in is returned unmodified
//
// Ports
//   clock       in   system clock
//   reset       in   synchronous active-high reset
//   cpu_rd      in   one-cycle CPU read strobe
//   cpu_addr    in   register offset: 0/1 status, 2 VRR low, 3 VRR high
//   ar_sel      in   current address-register select (0x02 = VRR)
//   status_in   in   live status byte
//   inc_sel     in   address step: 00 +1, 01 +32, 10 +64, 11 +128
//   marr_load   in   load read address and start a fetch
//   marr_value  in   new read address
//   cpu_dout    out  registered read data
//   status_rd   out  one-cycle pulse alongside a status read result
//   vram_req    out  VRAM read request, held until acked
//   vram_addr   out  VRAM read address, stable while vram_req is high
//   vram_ack    in   one-cycle ack; vram_rdata valid in the same cycle
//   vram_rdata  in   VRAM read data
// ---------------------------------------------------------------------------
module vdc_read_port #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic [1:0]    cpu_addr,
  input  logic [4:0]    ar_sel,
  input  logic [7:0]    status_in,
  input  logic [1:0]    inc_sel,
  input  logic          marr_load,
  input  logic [AW-1:0] marr_value,
  output logic [7:0]    cpu_dout,
  output logic          status_rd,
  output logic          vram_req,
  output logic [AW-1:0] vram_addr,
  input  logic          vram_ack,
  input  logic [DW-1:0] vram_rdata
);

  localparam logic [4:0] AR_VRR = 5'h02;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] vrr_q, vrr_d;
  logic          pending_q, pending_d;
  logic          discard_q, discard_d;
  logic          vram_req_q, vram_req_d;
  logic [AW-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          status_rd_q, status_rd_d;

  logic [AW-1:0] inc_step;
  logic          inc_trig;
  logic          fetch_req;
  logic [7:0]    status_byte;

  // Address step selected by the control register.
  always_comb begin
    inc_step = AW'(1);
    case (inc_sel)
      2'b00:   inc_step = AW'(1);
      2'b01:   inc_step = AW'(32);
      2'b10:   inc_step = AW'(64);
      default: inc_step = AW'(128);
    endcase
  end

  // A high-byte VRR read steps the address, unless a MARR load arrives in
  // the same cycle, which takes priority and swallows the increment.
  assign inc_trig  = cpu_rd && (cpu_addr == 2'd3) && (ar_sel == AR_VRR) && !marr_load;
  assign fetch_req = marr_load || inc_trig;

`ifdef READ_BUSY_STATUS_EN
  assign status_byte = {status_in[7], status_in[6] | (state_q == REQ), status_in[5:0]};
`else
  assign status_byte = status_in;
`endif

  // Read address: updated immediately, so any queued fetch uses the final value.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (marr_load) begin
      rd_addr_d = marr_value;
    end else if (inc_trig) begin
      rd_addr_d = rd_addr_q + inc_step;  // wraps modulo 2^AW
    end
  end

  // CPU read data path.
  always_comb begin
    cpu_dout_d  = cpu_dout_q;
    status_rd_d = 1'b0;
    if (cpu_rd) begin
      case (cpu_addr)
        2'd2:    cpu_dout_d = vrr_q[7:0];
        2'd3:    cpu_dout_d = vrr_q[15:8];
        default: begin
          cpu_dout_d  = status_byte;
          status_rd_d = 1'b1;
        end
      endcase
    end
  end

  // Fetch FSM.
  always_comb begin
    state_d     = state_q;
    vrr_d       = vrr_q;
    pending_d   = pending_q;
    discard_d   = discard_q;
    vram_req_d  = vram_req_q;
    vram_addr_d = vram_addr_q;
    case (state_q)
      IDLE: begin
        // Acks arriving here belong to no request and are ignored.
        if (fetch_req) begin
          vram_req_d  = 1'b1;
          vram_addr_d = rd_addr_d;
          pending_d   = 1'b0;
          discard_d   = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (vram_ack) begin
          // A MARR load in the ack cycle also invalidates this word.
          if (!discard_q && !marr_load) begin
            vrr_d = vram_rdata;
          end
          discard_d = 1'b0;
          pending_d = 1'b0;
          if (pending_q || fetch_req) begin
            vram_req_d  = 1'b1;
            vram_addr_d = rd_addr_d;
          end else begin
            vram_req_d = 1'b0;
            state_d    = IDLE;
          end
        end else if (fetch_req) begin
          // Single-depth queue: further requests merge into one refetch.
          pending_d = 1'b1;
          if (marr_load) begin
            discard_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        vram_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      vrr_q       <= '0;
      pending_q   <= 1'b0;
      discard_q   <= 1'b0;
      vram_req_q  <= 1'b0;
      vram_addr_q <= '0;
      cpu_dout_q  <= '0;
      status_rd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      vrr_q       <= vrr_d;
      pending_q   <= pending_d;
      discard_q   <= discard_d;
      vram_req_q  <= vram_req_d;
      vram_addr_q <= vram_addr_d;
      cpu_dout_q  <= cpu_dout_d;
      status_rd_q <= status_rd_d;
    end
  end

  assign cpu_dout  = cpu_dout_q;
  assign status_rd = status_rd_q;
  assign vram_req  = vram_req_q;
  assign vram_addr = vram_addr_q;

endmodule
